alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels, the shared-ALU drive/return and the response channel.
// Ports: req0_*/req1_* (valid, ready, op, rs1, rs2, imm), alu_* (op, rs1, rs2, imm, result),
//        rsp_* (valid, ready, id, data, err). slave = arbiter side, master = environment side.
interface alu_arbiter_if #(
    parameter int OP_W = 37
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OP_W-1:0] req0_op;
    logic [31:0]     req0_rs1;
    logic [31:0]     req0_rs2;
    logic [31:0]     req0_imm;

    logic            req1_valid;
    logic            req1_ready;
    logic [OP_W-1:0] req1_op;
    logic [31:0]     req1_rs1;
    logic [31:0]     req1_rs2;
    logic [31:0]     req1_imm;

    logic [OP_W-1:0] alu_op;
    logic [31:0]     alu_rs1;
    logic [31:0]     alu_rs2;
    logic [31:0]     alu_imm;
    logic [31:0]     alu_result;

    logic            rsp_valid;
    logic            rsp_ready;
    logic            rsp_id;
    logic [31:0]     rsp_data;
    logic            rsp_err;

    modport slave (
        input  req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm,
        input  req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm,
        output req0_ready, req1_ready,
        output alu_op, alu_rs1, alu_rs2, alu_imm,
        input  alu_result,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_rs1, req0_rs2, req0_imm,
        output req1_valid, req1_op, req1_rs1, req1_rs2, req1_imm,
        input  req0_ready, req1_ready,
        input  alu_op, alu_rs1, alu_rs2, alu_imm,
        output alu_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters, one op in flight.
// Latency: accept cycle -> one EXEC cycle -> response held in RESP; best-case initiation every 3 cycles.
// Ports: clk, rst (async active-high), bus (alu_arbiter_if.slave); readies drop while busy / response unread.
module alu_arbiter #(
    parameter int              OP_W     = 37,
    parameter logic [OP_W-1:0] OP_LEGAL = 37'h7FFFF
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic            rr_ptr;   // 1: req1 wins the next tie, 0: req0 wins
    logic            id_q;     // requester of the op in flight
    logic            err_q;    // op in flight is illegal

    logic [OP_W-1:0] alu_op_q;
    logic [31:0]     alu_rs1_q;
    logic [31:0]     alu_rs2_q;
    logic [31:0]     alu_imm_q;

    logic            rsp_valid_q;
    logic            rsp_id_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_err_q;

    logic            grant1;
    logic            xfer;
    logic [OP_W-1:0] sel_op;
    logic [31:0]     sel_rs1;
    logic [31:0]     sel_rs2;
    logic [31:0]     sel_imm;
    logic            sel_legal;

    // Exactly one bit set, and that bit inside the supported mask.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic [OP_W-1:0] one;
        one = {{(OP_W-1){1'b0}}, 1'b1};
        return (op != '0) && ((op & (op - one)) == '0) && ((op & ~OP_LEGAL) == '0);
    endfunction

    // req1 wins when it is the only one asking, or when both ask and the pointer favours it.
    assign grant1 = bus.req1_valid && (!bus.req0_valid || rr_ptr);
    assign xfer   = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant1;
    assign bus.req1_ready = (state == IDLE) && grant1;

    assign sel_op    = grant1 ? bus.req1_op  : bus.req0_op;
    assign sel_rs1   = grant1 ? bus.req1_rs1 : bus.req0_rs1;
    assign sel_rs2   = grant1 ? bus.req1_rs2 : bus.req0_rs2;
    assign sel_imm   = grant1 ? bus.req1_imm : bus.req0_imm;
    assign sel_legal = op_is_legal(sel_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            alu_op_q    <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_imm_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        // alu_op is loaded here so it is non-zero for exactly the EXEC cycle.
                        alu_op_q  <= sel_legal ? sel_op : '0;
                        alu_rs1_q <= sel_rs1;
                        alu_rs2_q <= sel_rs2;
                        alu_imm_q <= sel_imm;
                        err_q     <= !sel_legal;
                        id_q      <= grant1;
                        rr_ptr    <= !grant1;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= err_q ? 32'd0 : bus.alu_result;
                    rsp_err_q   <= err_q;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    alu_op_q    <= '0;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_op    = alu_op_q;
    assign bus.alu_rs1   = alu_rs1_q;
    assign bus.alu_rs2   = alu_rs2_q;
    assign bus.alu_imm   = alu_imm_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
